serial_rx: RTL and testbench



---
 rtl/serial_pkg.sv | 31 +++
 rtl/serial_rx_bit_sync.sv | 22 ++
 rtl/serial_rx.sv | 99 +++++++++
 tb/tb_serial_rx.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared serial-link definitions: receiver state encoding, default bit divisor, ASCII codes.
// Latency and backpressure: none, this package contains declarations only.
package serial_pkg;

  // Default divisor. Must match the transmitter's divisor.
  localparam int CLKS_PER_BIT_DFLT = 5208;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_1 = 8'h31;
  localparam logic [7:0] ASCII_2 = 8'h32;
  localparam logic [7:0] ASCII_3 = 8'h33;
  localparam logic [7:0] ASCII_4 = 8'h34;
  localparam logic [7:0] ASCII_5 = 8'h35;
  localparam logic [7:0] ASCII_6 = 8'h36;
  localparam logic [7:0] ASCII_7 = 8'h37;
  localparam logic [7:0] ASCII_8 = 8'h38;
  localparam logic [7:0] ASCII_9 = 8'h39;
  localparam logic [7:0] ASCII_U = 8'h75;

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return ASCII_0 + {4'h0, d};
  endfunction

endpackage

// File: rtl/serial_rx_bit_sync.sv
// 2-flop synchronizer for an asynchronous line. Both flops reset to 1, the idle level.
// Latency: 2 sysclk cycles. Backpressure: none.
module bit_sync (
  input  logic sysclk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_rx.sv
// 8N1 receiver. Each bit is sampled mid-bit; the byte is presented with a one-cycle valid strobe or a frame_err strobe.
// Latency: strobe at t0+HALF_BIT+9*CLKS_PER_BIT+1. Backpressure: none, and a strobe is lost if it is not consumed.
module serial_rx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DFLT
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state, state_nxt;
  logic             rx_s, rx_s_d;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;

  logic start_edge, cnt_half, cnt_bit;
  logic start_smp, data_smp, stop_smp, smp_pt;

  bit_sync u_sync (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .d      (rx),
    .q      (rx_s)
  );

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) rx_s_d <= 1'b1;
    else        rx_s_d <= rx_s;
  end

  // A falling edge is required, so a line held low cannot start a second frame.
  assign start_edge = rx_s_d & ~rx_s;
  assign cnt_half   = (clk_cnt == HALF_LAST);
  assign cnt_bit    = (clk_cnt == BIT_LAST);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_edge) state_nxt = START;
      START:   if (cnt_half) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (cnt_bit && bit_idx == 3'd7) state_nxt = STOP;
      STOP:    if (cnt_bit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    start_smp = (state == START) && cnt_half;
    data_smp  = (state == DATA) && cnt_bit;
    stop_smp  = (state == STOP) && cnt_bit;
    smp_pt    = start_smp | data_smp | stop_smp;
  end

  // Sample-point counter. It is held at zero in IDLE so that counting starts at t0+1.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt <= '0;
      bit_idx <= 3'd0;
    end else begin
      if (state == IDLE || smp_pt) clk_cnt <= '0;
      else                         clk_cnt <= clk_cnt + 1'b1;
      if (start_smp)     bit_idx <= 3'd0;
      else if (data_smp) bit_idx <= bit_idx + 3'd1;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (data_smp) shift_reg <= {rx_s, shift_reg[7:1]};
      if (stop_smp && rx_s) data <= shift_reg;
      valid     <= stop_smp & rx_s;
      frame_err <= stop_smp & ~rx_s;
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// Bench for serial_rx at CLKS_PER_BIT=16. It drives 8N1 frames aligned just after a clock edge.
// A scoreboard holds each expected strobe with its exact cycle.
module tb_serial_rx;

  localparam int CPB = 16;

  logic       sysclk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] dat;
    int         cyc;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] last_data;

  serial_rx #(.CLKS_PER_BIT(CPB)) dut (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // When a strobe appears, the monitor pops the oldest expectation and checks the kind, the data and the cycle.
  always @(negedge sysclk) begin
    if (rst_n && (valid || frame_err)) begin
      check_eq("strobe_exclusive", {31'd0, valid & frame_err}, 32'd0);
      if (sbq.size() == 0) begin
        check_eq("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check_eq("strobe_kind", {31'd0, frame_err}, {31'd0, e.is_err});
        check_eq("strobe_data", {24'd0, data}, {24'd0, e.dat});
        check_eq("strobe_cycle", cyc, e.cyc);
      end
    end
  end

  // The start edge is driven at cycle c0. The strobe is seen at c0+155: 2 sync cycles + 1 edge cycle + 8 + 9*16.
  task automatic push_exp(input bit is_err, input logic [7:0] d);
    exp_t e;
    e.is_err = is_err;
    e.dat    = d;
    e.cyc    = cyc + 3 + CPB / 2 + 9 * CPB;
    sbq.push_back(e);
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    if (stop_v) begin
      push_exp(1'b0, b);
      last_data = b;
    end else begin
      push_exp(1'b1, last_data);
    end
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop_v, CPB);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    rx        = 1'b1;
    last_data = 8'h00;
    repeat (3) @(posedge sysclk);
    #1;
    check_eq("rst_data", {24'd0, data}, 32'd0);
    check_eq("rst_valid", {31'd0, valid}, 32'd0);
    check_eq("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    hold(1'b1, 4);

    // Single frame '5'
    send_frame(8'h35, 1'b1);
    hold(1'b1, 10);

    // 'u' and '0' back to back with no idle bits between them
    send_frame(8'h75, 1'b1);
    send_frame(8'h30, 1'b1);
    hold(1'b1, 10);

    // A 5-cycle low glitch raises busy, and the receiver then returns to idle
    hold(1'b0, 4);
    check_eq("glitch_busy_hi", {31'd0, busy}, 32'd1);
    hold(1'b0, 1);
    hold(1'b1, 40);
    check_eq("glitch_busy_lo", {31'd0, busy}, 32'd0);
    check_eq("glitch_data", {24'd0, data}, 32'h30);

    // Stop bit forced low, then a normal frame after the line has been idle
    send_frame(8'h39, 1'b0);
    hold(1'b1, 2 * CPB);
    send_frame(8'h31, 1'b1);
    hold(1'b1, 10);

    // Reset asserted during data bit 4
    rx = 1'b0;
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(1'b1, CPB);
    hold(1'b0, 8);
    check_eq("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_data", {24'd0, data}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    @(posedge sysclk);
    #1;
    rst_n     = 1'b1;
    last_data = 8'h00;
    hold(1'b1, 200);
    check_eq("post_rst_data", {24'd0, data}, 32'd0);
    send_frame(8'h32, 1'b1);
    hold(1'b1, 10);

    // Line held low for 20 bit times gives exactly one framing error
    push_exp(1'b1, last_data);
    hold(1'b0, 20 * CPB);
    check_eq("stuck_low_busy", {31'd0, busy}, 32'd0);
    hold(1'b1, 300);

    check_eq("sb_empty", sbq.size(), 32'd0);
    check_eq("final_data", {24'd0, data}, 32'h32);
    check_eq("final_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
